// File: rtl/sram_controller_if.sv
// Core-side MEM-stage bus between the pipeline and sram_controller.
//   wr_en/rd_en      : store/load request, held stable while ready=0
//   address          : 32-bit byte address
//   write_data       : 32-bit store data
//   read_data        : 32-bit assembled load data
//   ready            : 1 = no access pending or access completing this cycle
// master = pipeline side, slave = controller side.
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// Sequences 32-bit MEM-stage loads/stores onto a 16-bit asynchronous SRAM as
// two half-word accesses (low half, then high half), each held WAIT_CYCLES clocks.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-high reset
//   bus          : core-side request/response interface (slave modport)
//   sram_addr    : SRAM half-word address
//   sram_dq_out  : data driven to the SRAM DQ bus
//   sram_dq_oe   : 1 = drive sram_dq_out onto DQ (tristate lives at top level)
//   sram_dq_in   : data sampled from the SRAM DQ bus
//   sram_we_n    : SRAM write strobe, active low
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned ADDR_W      = 18,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  sram_controller_if.slave  bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_we_n
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(WAIT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              is_wr_q;
  logic [31:0]       read_data_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [15:0]       sram_dq_out_q;
  logic              sram_dq_oe_q;
  logic              sram_we_n_q;

  logic              req_c;
  logic [31:0]       word_c;
  logic [ADDR_W-1:0] lo_addr_c;

  assign req_c = bus.wr_en | bus.rd_en;

  // Byte address to half-word address; out-of-range addresses wrap silently.
  assign word_c    = (bus.address - BASE_ADDR) >> 2;
  assign lo_addr_c = ADDR_W'({word_c, 1'b0});

  // Sequencer: pin outputs are loaded on the edge entering each phase so they
  // are valid for the whole phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      is_wr_q       <= 1'b0;
      read_data_q   <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_c) begin
            state_q       <= LOW;
            cnt_q         <= '0;
            is_wr_q       <= bus.wr_en;
            sram_addr_q   <= lo_addr_c;
            sram_dq_out_q <= bus.write_data[15:0];
            sram_dq_oe_q  <= bus.wr_en;
            sram_we_n_q   <= ~bus.wr_en;
          end
        end
        LOW, HIGH: begin
          if (cnt_q == LAST_CNT) begin
            cnt_q <= '0;
            if (state_q == LOW) begin
              if (!is_wr_q) read_data_q[15:0] <= sram_dq_in;
              state_q       <= HIGH;
              sram_addr_q   <= sram_addr_q | ADDR_W'(1);
              sram_dq_out_q <= bus.write_data[31:16];
              sram_dq_oe_q  <= is_wr_q;
              sram_we_n_q   <= ~is_wr_q;
            end else begin
              if (!is_wr_q) read_data_q[31:16] <= sram_dq_in;
              state_q      <= DONE;
              sram_dq_oe_q <= 1'b0;
              sram_we_n_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            // Release we_n one clock early so data is held past the strobe edge.
            if (cnt_q == HOLD_CNT) sram_we_n_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // ready is combinational in IDLE so an idle controller never stalls the core.
  assign bus.ready     = (state_q == IDLE) ? ~req_c : (state_q == DONE);
  assign bus.read_data = read_data_q;
  assign sram_addr     = sram_addr_q;
  assign sram_dq_out   = sram_dq_out_q;
  assign sram_dq_oe    = sram_dq_oe_q;
  assign sram_we_n     = sram_we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM model.
module tb_sram_controller;
  localparam int unsigned WC     = 5;
  localparam int unsigned ADDR_W = 18;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic [15:0]       sram_dq_in;
  logic              sram_we_n;

  sram_controller_if bus ();

  sram_controller #(.WAIT_CYCLES(WC), .ADDR_W(ADDR_W), .BASE_ADDR(32'd1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_dq_in (sram_dq_in),
    .sram_we_n  (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: a write lands on every clock the strobe is active.
  logic [15:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (sram_dq_oe && !sram_we_n) mem[sram_addr] <= sram_dq_out;
  end
  assign sram_dq_in = mem[sram_addr];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] addr_lo_seen;
  logic [31:0] addr_hi_seen;
  int          xs_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full access starting in IDLE; samples cycles 0..2*WC+1 on the falling edge.
  task automatic do_access(input string tag, input logic wr, input logic rd,
                           input logic [31:0] addr, input logic [31:0] data,
                           input bit hold);
    int low_cnt;
    int we_lo;
    int oe_hi;
    low_cnt = 0; we_lo = 0; oe_hi = 0; xs_seen = 0;
    @(posedge clk); #1;
    bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.write_data = data;
    for (int c = 0; c <= 2*WC; c++) begin
      @(negedge clk);
      if (bus.ready === 1'b0) low_cnt++;
      if (sram_we_n === 1'b0) we_lo++;
      if (sram_dq_oe === 1'b1) oe_hi++;
      if ($isunknown({sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, bus.ready})) xs_seen++;
      if (c == 1) addr_lo_seen = 32'(sram_addr);
      if (c == WC + 1) addr_hi_seen = 32'(sram_addr);
    end
    @(negedge clk);
    check({tag, "_ready_low"}, 32'(low_cnt), 32'(2*WC+1));
    check({tag, "_ready_done"}, 32'(bus.ready), 32'd1);
    check({tag, "_we_lo"}, 32'(we_lo), wr ? 32'(2*(WC-1)) : 32'd0);
    check({tag, "_oe_hi"}, 32'(oe_hi), wr ? 32'(2*WC) : 32'd0);
    if (!hold) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
    #12;
    // Reset state
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_rdata", bus.read_data, 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    @(negedge clk); rst = 1'b0;

    // 1. Write 0xDEADBEEF @1028 -> hw2/hw3
    do_access("t1_wr", 1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
    check("t1_hw2", 32'(mem[2]), 32'h0000BEEF);
    check("t1_hw3", 32'(mem[3]), 32'h0000DEAD);
    check("t1_addr_lo", addr_lo_seen, 32'd2);
    check("t1_addr_hi", addr_hi_seen, 32'd3);

    // 2. Read back @1028
    do_access("t2_rd", 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    check("t2_rdata", bus.read_data, 32'hDEADBEEF);

    // 3. Both enables set: write wins, read_data untouched
    do_access("t3_both", 1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
    check("t3_hw0", 32'(mem[0]), 32'h00005678);
    check("t3_hw1", 32'(mem[1]), 32'h00001234);
    check("t3_rdata", bus.read_data, 32'hDEADBEEF);

    // 4. Read held through DONE, then a second read in IDLE
    do_access("t4_rd_a", 1'b0, 1'b1, 32'd1024, 32'h0, 1'b1);
    check("t4_rdata_a", bus.read_data, 32'h12345678);
    do_access("t4_rd_b", 1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    check("t4_rdata_b", bus.read_data, 32'hDEADBEEF);
    @(negedge clk);
    check("t4_idle_ready", 32'(bus.ready), 32'd1);

    // 5. Reset in the middle of the high half of a write
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.address = 32'd1036; bus.write_data = 32'hCAFEF00D;
    repeat (WC + 2) @(negedge clk);
    check("t5_pre_we_n", 32'(sram_we_n), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_we_n", 32'(sram_we_n), 32'd1);
    check("t5_rst_oe", 32'(sram_dq_oe), 32'd0);
    check("t5_rst_rdata", bus.read_data, 32'h0);
    bus.wr_en = 1'b0;
    #1;
    check("t5_rst_ready", 32'(bus.ready), 32'd1);
    @(negedge clk); rst = 1'b0;
    do_access("t5_wr", 1'b1, 1'b0, 32'd1036, 32'h0BADF00D, 1'b0);
    check("t5_hw6", 32'(mem[6]), 32'h0000F00D);
    check("t5_hw7", 32'(mem[7]), 32'h00000BAD);

    // 6. Address below the base wraps to the top of the SRAM
    do_access("t6_wrap", 1'b1, 1'b0, 32'd1020, 32'hA5A55A5A, 1'b0);
    check("t6_addr_lo", addr_lo_seen, 32'((1 << ADDR_W) - 2));
    check("t6_addr_hi", addr_hi_seen, 32'((1 << ADDR_W) - 1));
    check("t6_no_x", 32'(xs_seen), 32'd0);
    check("t6_hw_top_lo", 32'(mem[(1<<ADDR_W)-2]), 32'h00005A5A);
    check("t6_hw_top_hi", 32'(mem[(1<<ADDR_W)-1]), 32'h0000A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
